// File: rtl/aes_pkg.sv
// Shared AES-128 types, round constants and GF(2^8) column arithmetic.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    localparam byte_t RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes are MSB-first: w[31:24] is row 0.
    function automatic word_t mix_column(input word_t w);
        byte_t a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 (and maps 0 to 0); 254 has bits 1..7 set.
    function automatic byte_t gf_inv(input byte_t a);
        byte_t r;
        byte_t p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    byte_t w_inv;

    always_comb begin
        w_inv  = gf_inv(i_byte);
        o_byte = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;
    end

endmodule

// File: rtl/aes_128.sv
// Fully pipelined AES-128 encryptor: one block per cycle, 21 register stages from inputs to out.
module aes_128
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         nreset,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out
);

    block_t r_s0;
    block_t r_k0;
    block_t w_st  [0:10];
    block_t w_key [0:9];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_s0 <= '0;
            r_k0 <= '0;
        end else begin
            r_s0 <= state ^ key;
            r_k0 <= key;
        end
    end

    assign w_st[0]  = r_s0;
    assign w_key[0] = r_k0;

    for (genvar r = 1; r <= 10; r++) begin : g_round
        block_t r_sb;
        block_t r_ka;
        block_t r_st;
        block_t w_sb;
        block_t w_sr;
        block_t w_mc;
        word_t  w_sw;
        word_t  w_t;
        word_t  w_n0, w_n1, w_n2, w_n3;

        for (genvar i = 0; i < 16; i++) begin : g_sub
            aes_sbox u_sbox (
                .i_byte (w_st[r-1][127-8*i -: 8]),
                .o_byte (w_sb[127-8*i -: 8])
            );
        end

        // RotWord folded into the S-box wiring: output byte j reads word-3 byte (j+1)%4.
        for (genvar j = 0; j < 4; j++) begin : g_ksub
            aes_sbox u_sbox (
                .i_byte (w_key[r-1][31-8*((j+1)%4) -: 8]),
                .o_byte (w_sw[31-8*j -: 8])
            );
        end

        assign w_t  = w_sw ^ {RCON[r-1], 24'h000000};
        assign w_n0 = w_key[r-1][127:96] ^ w_t;
        assign w_n1 = w_key[r-1][95:64]  ^ w_n0;
        assign w_n2 = w_key[r-1][63:32]  ^ w_n1;
        assign w_n3 = w_key[r-1][31:0]   ^ w_n2;

        for (genvar c = 0; c < 4; c++) begin : g_col
            for (genvar row = 0; row < 4; row++) begin : g_row
                assign w_sr[127-8*(4*c+row) -: 8] = r_sb[127-8*(4*((c+row)%4)+row) -: 8];
            end
            if (r == 10) begin : g_last
                assign w_mc[127-32*c -: 32] = w_sr[127-32*c -: 32];
            end else begin : g_mix
                assign w_mc[127-32*c -: 32] = mix_column(w_sr[127-32*c -: 32]);
            end
        end

        // Cycle A registers SubBytes and k_r; cycle B adds k_r from r_ka, which is now aligned.
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                r_sb <= '0;
                r_ka <= '0;
                r_st <= '0;
            end else begin
                r_sb <= w_sb;
                r_ka <= {w_n0, w_n1, w_n2, w_n3};
                r_st <= w_mc ^ r_ka;
            end
        end

        assign w_st[r] = r_st;

        if (r < 10) begin : g_kdly
            block_t r_kb;

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    r_kb <= '0;
                end else begin
                    r_kb <= r_ka;
                end
            end

            assign w_key[r] = r_kb;
        end
    end

    assign out = w_st[10];

endmodule

// File: tb/tb_aes_128.sv
// Directed FIPS-197 vectors plus random back-to-back blocks checked against a byte-level AES model.
module tb_aes_128;

    logic         clk = 1'b0;
    logic         nreset = 1'b1;
    logic [127:0] st_i = '0;
    logic [127:0] key_i = '0;
    logic [127:0] out_o;

    always #5 clk = ~clk;

    aes_128 dut (
        .clk    (clk),
        .nreset (nreset),
        .state  (st_i),
        .key    (key_i),
        .out    (out_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    logic [127:0] exp_v   [0:1023];
    bit           exp_ok  [0:1023];
    string        exp_tag [0:1023];
    logic [127:0] cur_exp = '0;
    string        cur_tag = "idle";
    logic [7:0]   sbox_t  [0:255];

    function automatic logic [7:0] mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    // S-box table from the generator 3 walk: p = 3^k, q = p^-1.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0]   ks [0:175];
        logic [7:0]   s  [0:15];
        logic [7:0]   t  [0:15];
        logic [7:0]   tw [0:3];
        logic [7:0]   rc, tmp, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            ks[i] = k[127-8*i -: 8];
            s[i]  = pt[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tw[j] = ks[i-4+j];
            if (i % 16 == 0) begin
                tmp   = tw[0];
                tw[0] = sbox_t[tw[1]] ^ rc;
                tw[1] = sbox_t[tw[2]];
                tw[2] = sbox_t[tw[3]];
                tw[3] = sbox_t[tmp];
                rc    = mul2(rc);
            end
            for (int j = 0; j < 4; j++) ks[i+j] = ks[i-16+j] ^ tw[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
                    s[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[16*rnd+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
        end
    endtask

    // Inputs present now are sampled at edge_n+1 and must emerge right after edge_n+21.
    task automatic cycle();
        if (nreset) begin
            exp_v[edge_n+21]   = cur_exp;
            exp_ok[edge_n+21]  = 1'b1;
            exp_tag[edge_n+21] = cur_tag;
        end
        @(posedge clk);
        edge_n++;
        #1;
        if (!nreset) chk("rst_hold", out_o, 128'h0);
        else if (exp_ok[edge_n]) chk(exp_tag[edge_n], out_o, exp_v[edge_n]);
    endtask

    task automatic set_dir(input string tag, input logic [127:0] k, input logic [127:0] s,
                           input logic [127:0] e);
        key_i   = k;
        st_i    = s;
        cur_exp = e;
        cur_tag = tag;
    endtask

    task automatic set_rand();
        key_i   = {$urandom, $urandom, $urandom, $urandom};
        st_i    = {$urandom, $urandom, $urandom, $urandom};
        cur_exp = aes_ref(key_i, st_i);
        cur_tag = "rand";
    endtask

    task automatic clear_future();
        for (int i = edge_n + 1; i < 1024; i++) exp_ok[i] = 1'b0;
    endtask

    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] CK1 = 128'h0545aad56da2a97c3663d1432a3d1c84;
    localparam logic [127:0] CS1 = 128'h58e2fccefa7e3061367f1d57a4e7455a;

    initial begin
        build_sbox();
        chk("model_appB", aes_ref(KB, SB), CB);
        chk("model_appC", aes_ref(KC, SC), CC);
        chk("model_zero", aes_ref(128'h0, 128'h0), CZ);
        chk("model_key1", aes_ref(128'h1, 128'h0), CK1);
        chk("model_st1",  aes_ref(128'h0, 128'h1), CS1);

        #2 nreset = 1'b0;
        #1 chk("rst_init", out_o, 128'h0);
        repeat (3) cycle();
        #2 nreset = 1'b1;

        set_dir("appB", KB, SB, CB);               cycle();
        set_dir("appC", KC, SC, CC);               cycle();
        set_dir("zero", 128'h0, 128'h0, CZ);       cycle();
        set_dir("key1", 128'h1, 128'h0, CK1);      cycle();
        set_dir("st1",  128'h0, 128'h1, CS1);      cycle();
        repeat (60) begin
            set_rand();
            cycle();
        end

        #3 nreset = 1'b0;
        #1 chk("rst_async", out_o, 128'h0);
        clear_future();
        repeat (2) cycle();
        #2 nreset = 1'b1;

        set_dir("appC_after_rst", KC, SC, CC);     cycle();
        repeat (25) begin
            set_rand();
            cycle();
        end
        repeat (22) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
